// File: rtl/vx_bank_sched_pkg.sv
// Shared cache definitions: stage-0 source encodings and the bank scheduler FSM states.
package vx_bank_sched_pkg;

  localparam logic [1:0] SEL_CORE   = 2'd0;
  localparam logic [1:0] SEL_REPLAY = 2'd1;
  localparam logic [1:0] SEL_FILL   = 2'd2;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_REPLAY = 1'b1
  } sched_state_e;

endpackage

// File: rtl/vx_bank_sched_pipe_reg.sv
// Stage-0 output register of the bank scheduler; loads when enabled and holds otherwise.
module vx_bank_sched_pipe_reg #(
  parameter int ADDR_W = 26,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              load_valid,
  input  logic [1:0]        load_sel,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              vld_p0,
  output logic [1:0]        sel_p0,
  output logic [ADDR_W-1:0] addr_p0,
  output logic [DATA_W-1:0] data_p0
);

  // Stage 0: a reset drops any held entry outright; the source is not retried.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p0  <= 1'b0;
      sel_p0  <= 2'd0;
      addr_p0 <= '0;
      data_p0 <= '0;
    end else if (en) begin
      vld_p0  <= load_valid;
      sel_p0  <= load_sel;
      addr_p0 <= load_addr;
      data_p0 <= load_data;
    end
  end

endmodule

// File: rtl/vx_bank_sched.sv
// Bank request scheduler: arbitrates fill > replay > core into one stage-0 register,
// with a post-fill replay phase, core starvation override and core credit tracking.
module vx_bank_sched
  import vx_bank_sched_pkg::*;
#(
  parameter int LINE_ADDR_WIDTH = 26,
  parameter int PAYLOAD_W       = 64,
  parameter int CREDITS         = 4,
  parameter int STARVE_LIMIT    = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       core_req_valid,
  input  logic [LINE_ADDR_WIDTH-1:0] core_req_addr,
  input  logic [PAYLOAD_W-1:0]       core_req_data,
  output logic                       core_req_ready,
  input  logic                       fill_valid,
  input  logic [LINE_ADDR_WIDTH-1:0] fill_addr,
  input  logic [PAYLOAD_W-1:0]       fill_data,
  output logic                       fill_ready,
  input  logic                       mshr_sched_valid,
  input  logic [LINE_ADDR_WIDTH-1:0] mshr_sched_addr,
  input  logic [PAYLOAD_W-1:0]       mshr_sched_data,
  output logic                       mshr_schedule,
  input  logic                       core_retire,
  output logic                       pipe_valid,
  output logic [1:0]                 pipe_sel,
  output logic [LINE_ADDR_WIDTH-1:0] pipe_addr,
  output logic [PAYLOAD_W-1:0]       pipe_data,
  input  logic                       pipe_ready
);

  localparam int CRD_W = $clog2(CREDITS + 1);
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  sched_state_e               state;
  logic [STV_W-1:0]           starve;
  logic [CRD_W-1:0]           credits;
  logic                       advance;
  logic                       core_elig;
  logic                       starved;
  logic                       grant_fill;
  logic                       grant_replay;
  logic                       grant_core;
  logic [1:0]                 load_sel;
  logic [LINE_ADDR_WIDTH-1:0] load_addr;
  logic [PAYLOAD_W-1:0]       load_data;

  assign advance   = !pipe_valid || pipe_ready;
  assign core_elig = core_req_valid && (credits != '0) && (state == ST_IDLE);
  assign starved   = (starve == STV_W'(STARVE_LIMIT));

  // Starvation lets core overtake replay, but a pending fill always wins.
  assign grant_fill   = reset && advance && fill_valid;
  assign grant_replay = reset && advance && !fill_valid && mshr_sched_valid
                        && !(core_elig && starved);
  assign grant_core   = reset && advance && !fill_valid && core_elig
                        && (!mshr_sched_valid || starved);

  assign fill_ready     = grant_fill;
  assign mshr_schedule  = grant_replay;
  assign core_req_ready = grant_core;

  always_comb begin
    load_sel  = SEL_CORE;
    load_addr = core_req_addr;
    load_data = core_req_data;
    if (grant_fill) begin
      load_sel  = SEL_FILL;
      load_addr = fill_addr;
      load_data = fill_data;
    end else if (grant_replay) begin
      load_sel  = SEL_REPLAY;
      load_addr = mshr_sched_addr;
      load_data = mshr_sched_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      starve  <= '0;
      credits <= CRD_W'(CREDITS);
    end else begin
      case (state)
        ST_IDLE:   if (grant_fill) state <= ST_REPLAY;
        ST_REPLAY: if (advance && !mshr_sched_valid && !fill_valid) state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase

      if (grant_core || !core_req_valid)
        starve <= '0;
      else if (grant_replay && core_elig && !starved)
        starve <= starve + STV_W'(1);

      // A retire with every credit already home is a protocol error; hold at the cap.
      case ({grant_core, core_retire})
        2'b10:   credits <= credits - CRD_W'(1);
        2'b01:   if (credits != CRD_W'(CREDITS)) credits <= credits + CRD_W'(1);
        default: credits <= credits;
      endcase
    end
  end

  assert property (@(posedge clk) disable iff (!reset)
                   !(core_retire && credits == CRD_W'(CREDITS)));

  vx_bank_sched_pipe_reg #(
    .ADDR_W (LINE_ADDR_WIDTH),
    .DATA_W (PAYLOAD_W)
  ) u_pipe_reg (
    .clk        (clk),
    .reset      (reset),
    .en         (advance),
    .load_valid (grant_fill || grant_replay || grant_core),
    .load_sel   (load_sel),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .vld_p0     (pipe_valid),
    .sel_p0     (pipe_sel),
    .addr_p0    (pipe_addr),
    .data_p0    (pipe_data)
  );

endmodule

// File: tb/tb_vx_bank_sched.sv
// Directed bench for vx_bank_sched: priority, replay phase, starvation, credits, stall, reset.
module tb_vx_bank_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_req_valid, fill_valid, mshr_sched_valid, core_retire, pipe_ready;
  logic [25:0] core_req_addr, fill_addr, mshr_sched_addr;
  logic [63:0] core_req_data, fill_data, mshr_sched_data;
  logic        core_req_ready, fill_ready, mshr_schedule, pipe_valid;
  logic [1:0]  pipe_sel;
  logic [25:0] pipe_addr;
  logic [63:0] pipe_data;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  vx_bank_sched dut (
    .clk              (clk),
    .reset            (reset),
    .core_req_valid   (core_req_valid),
    .core_req_addr    (core_req_addr),
    .core_req_data    (core_req_data),
    .core_req_ready   (core_req_ready),
    .fill_valid       (fill_valid),
    .fill_addr        (fill_addr),
    .fill_data        (fill_data),
    .fill_ready       (fill_ready),
    .mshr_sched_valid (mshr_sched_valid),
    .mshr_sched_addr  (mshr_sched_addr),
    .mshr_sched_data  (mshr_sched_data),
    .mshr_schedule    (mshr_schedule),
    .core_retire      (core_retire),
    .pipe_valid       (pipe_valid),
    .pipe_sel         (pipe_sel),
    .pipe_addr        (pipe_addr),
    .pipe_data        (pipe_data),
    .pipe_ready       (pipe_ready)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic strobes(input string tag, input logic f, input logic r, input logic c);
    check_eq({tag, " fill_ready"}, 64'(fill_ready), 64'(f));
    check_eq({tag, " mshr_schedule"}, 64'(mshr_schedule), 64'(r));
    check_eq({tag, " core_req_ready"}, 64'(core_req_ready), 64'(c));
  endtask

  initial begin
    reset = 1'b1;
    core_req_valid = 1'b1; fill_valid = 1'b1; mshr_sched_valid = 1'b1;
    core_retire = 1'b0; pipe_ready = 1'b1;
    core_req_addr = 26'h11; core_req_data = 64'hC0;
    fill_addr = 26'hA1; fill_data = 64'hF111;
    mshr_sched_addr = 26'h0; mshr_sched_data = 64'h0;
    #2 reset = 1'b0;
    #1;
    // reset state, strobes held low even with every source valid
    check_eq("rst pipe_valid", 64'(pipe_valid), 64'd0);
    check_eq("rst pipe_sel", 64'(pipe_sel), 64'd0);
    check_eq("rst pipe_addr", 64'(pipe_addr), 64'd0);
    check_eq("rst pipe_data", pipe_data, 64'd0);
    check_eq("rst credits", 64'(dut.credits), 64'd4);
    check_eq("rst state", 64'(dut.state), 64'd0);
    strobes("rst", 1'b0, 1'b0, 1'b0);
    step();
    step();
    reset = 1'b1;
    #1;

    // all three valid: fill wins, lands next cycle, FSM enters replay
    strobes("pri", 1'b1, 1'b0, 1'b0);
    step();
    check_eq("pri pipe_valid", 64'(pipe_valid), 64'd1);
    check_eq("pri pipe_sel", 64'(pipe_sel), 64'd2);
    check_eq("pri pipe_addr", 64'(pipe_addr), 64'hA1);
    check_eq("pri pipe_data", pipe_data, 64'hF111);
    check_eq("pri state", 64'(dut.state), 64'd1);
    fill_valid = 1'b0;

    // replay phase: three replays, core locked out, then back to idle
    for (int i = 0; i < 3; i++) begin
      mshr_sched_addr = 26'(26'h200 + i);
      mshr_sched_data = 64'(64'hBEE0 + i);
      #1;
      strobes("rep", 1'b0, 1'b1, 1'b0);
      step();
      check_eq("rep pipe_sel", 64'(pipe_sel), 64'd1);
      check_eq("rep pipe_addr", 64'(pipe_addr), 64'(26'h200 + i));
      check_eq("rep state", 64'(dut.state), 64'd1);
    end
    mshr_sched_valid = 1'b0;
    #1;
    strobes("rep4", 1'b0, 1'b0, 1'b0);
    step();
    check_eq("rep4 state", 64'(dut.state), 64'd0);
    check_eq("rep4 pipe_valid", 64'(pipe_valid), 64'd0);
    check_eq("rep4 starve", 64'(dut.starve), 64'd0);

    // starvation: 8 replay wins, then core forced through
    mshr_sched_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      #1;
      strobes("stv", 1'b0, i < 8, i == 8);
      step();
      if (i == 7) check_eq("stv starve full", 64'(dut.starve), 64'd8);
    end
    check_eq("stv pipe_sel", 64'(pipe_sel), 64'd0);
    check_eq("stv pipe_addr", 64'(pipe_addr), 64'h11);
    check_eq("stv starve clr", 64'(dut.starve), 64'd0);
    check_eq("stv credits", 64'(dut.credits), 64'd3);
    core_req_valid = 1'b0;
    mshr_sched_valid = 1'b0;

    // credits: restore to 4, then five requests with no retire
    core_retire = 1'b1;
    step();
    core_retire = 1'b0;
    check_eq("crd refill", 64'(dut.credits), 64'd4);
    core_req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      core_req_addr = 26'(26'h300 + i);
      #1;
      check_eq("crd grant", 64'(core_req_ready), 64'(i < 4));
      step();
    end
    check_eq("crd empty", 64'(dut.credits), 64'd0);
    core_retire = 1'b1;
    #1;
    check_eq("crd retire cycle", 64'(core_req_ready), 64'd0);
    step();
    core_retire = 1'b0;
    #1;
    check_eq("crd 5th grant", 64'(core_req_ready), 64'd1);
    step();
    check_eq("crd 5th addr", 64'(pipe_addr), 64'h304);
    check_eq("crd after 5th", 64'(dut.credits), 64'd0);
    core_req_valid = 1'b0;
    core_retire = 1'b1;
    repeat (4) step();
    core_retire = 1'b0;
    check_eq("crd restored", 64'(dut.credits), 64'd4);

    // stall: entry held while pipe_ready is low, grant resumes same cycle
    pipe_ready = 1'b0;
    core_req_valid = 1'b1;
    core_req_addr = 26'h401;
    core_req_data = 64'hD401;
    #1;
    check_eq("stl first grant", 64'(core_req_ready), 64'd1);
    step();
    core_req_addr = 26'h402;
    core_req_data = 64'hD402;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_eq("stl no grant", 64'(core_req_ready), 64'd0);
      check_eq("stl hold valid", 64'(pipe_valid), 64'd1);
      check_eq("stl hold addr", 64'(pipe_addr), 64'h401);
      check_eq("stl hold data", pipe_data, 64'hD401);
      step();
    end
    pipe_ready = 1'b1;
    #1;
    check_eq("stl release grant", 64'(core_req_ready), 64'd1);
    step();
    check_eq("stl new addr", 64'(pipe_addr), 64'h402);
    check_eq("stl credits", 64'(dut.credits), 64'd2);
    core_req_valid = 1'b0;
    pipe_ready = 1'b0;

    // reset mid-operation drops the held entry at once
    check_eq("mid pre valid", 64'(pipe_valid), 64'd1);
    reset = 1'b0;
    #1;
    check_eq("mid pipe_valid", 64'(pipe_valid), 64'd0);
    check_eq("mid pipe_addr", 64'(pipe_addr), 64'd0);
    step();
    reset = 1'b1;
    step();
    check_eq("mid credits", 64'(dut.credits), 64'd4);
    check_eq("mid post valid", 64'(pipe_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vx_bank_sched.md
VX_BANK_SCHED -- requirements
Module: VX_bank_sched

Interface
REQ-001 SHALL have parameter LINE_ADDR_WIDTH, default 26, line address width.
REQ-002 SHALL have parameter PAYLOAD_W, default 64, width of request/fill/replay payload.
REQ-003 SHALL have parameter CREDITS, default 4, maximum core requests in flight in the bank pipeline.
REQ-004 SHALL have parameter STARVE_LIMIT, default 8, replay-win cycles before a core request is forced through.
REQ-005 SHALL have ports:
clk  in  1  clock.
reset  in  1  asynchronous active-low reset.
core_req_valid  in  1  core request present.
core_req_addr  in  LINE_ADDR_WIDTH  core line address.
core_req_data  in  PAYLOAD_W  core payload.
core_req_ready  out  1  core request granted this cycle.
fill_valid  in  1  memory fill present.
fill_addr  in  LINE_ADDR_WIDTH  fill line address.
fill_data  in  PAYLOAD_W  fill payload.
fill_ready  out  1  fill granted this cycle.
mshr_sched_valid  in  1  MSHR has a ready entry (its schedule_valid).
mshr_sched_addr  in  LINE_ADDR_WIDTH  MSHR entry address.
mshr_sched_data  in  PAYLOAD_W  MSHR entry data.
mshr_schedule  out  1  replay granted; drives MSHR schedule.
core_retire  in  1  one core request left the pipeline (hit or MSHR-enqueued).
pipe_valid  out  1  stage-0 entry valid.
pipe_sel  out  2  source: 0 core, 1 replay, 2 fill.
pipe_addr  out  LINE_ADDR_WIDTH  stage-0 address.
pipe_data  out  PAYLOAD_W  stage-0 payload.
pipe_ready  in  1  pipeline accepts stage-0 entry.

Function
REQ-006 Output register SHALL advance when !pipe_valid || pipe_ready; grants SHALL occur only in advance cycles; at most one grant per cycle.
REQ-007 Granted source SHALL appear on pipe_* exactly one cycle after grant; pipe_* SHALL hold stable while pipe_valid && !pipe_ready.
REQ-008 core_req_ready, fill_ready, mshr_schedule SHALL be combinational, mutually exclusive grant strobes.
REQ-009 Priority SHALL be fill > replay > core, except REQ-012 override.
REQ-010 FSM SHALL have states IDLE, REPLAY: IDLE->REPLAY on fill grant; REPLAY->IDLE in an advance cycle with !mshr_sched_valid && !fill_valid; otherwise stay.
REQ-011 In REPLAY, core SHALL never be granted.
REQ-012 Starve counter (0..STARVE_LIMIT) SHALL increment each IDLE cycle where core is eligible but replay wins; at STARVE_LIMIT core SHALL beat replay (never fill); counter SHALL clear on core grant or !core_req_valid.
REQ-013 Credit counter ($clog2(CREDITS+1) bits) SHALL decrement on core grant, increment on core_retire, be unchanged when both occur; core eligible only when credits > 0.
REQ-014 core_retire with credits == CREDITS SHALL fire an assertion and saturate.
REQ-015 Grant strobes SHALL be 0 whenever the corresponding valid is 0.

Reset
REQ-016 On reset low, asynchronously: pipe_valid=0, pipe_sel=0, pipe_addr=0, pipe_data=0, FSM=IDLE, starve=0, credits=CREDITS; grant strobes 0 while reset asserted.
REQ-017 Reset mid-operation SHALL drop the held stage-0 entry without retry.

Structure
REQ-018 Source encodings (SEL_CORE/SEL_REPLAY/SEL_FILL) and FSM state enum SHALL live in the shared cache package.
REQ-019 Output stage SHALL be one VX_pipe_register instance; arbitration, FSM and counters inline.

Verification
REQ-020 fill_valid, mshr_sched_valid, core_req_valid all 1, pipe_ready=1 -> fill_ready cycle 0, pipe_sel=2 cycle 1, FSM=REPLAY.
REQ-021 REPLAY with mshr_sched_valid held 3 cycles then low -> 3 mshr_schedule pulses, zero core grants, IDLE on 4th advance cycle.
REQ-022 IDLE, replay and core continuously valid, STARVE_LIMIT=8 -> 8 replay grants then one core grant, counter reads 0.
REQ-023 CREDITS=4, 5 core requests, no retire -> 4 grants, 5th stalls; one core_retire -> 5th granted next cycle.
REQ-024 pipe_ready=0 for 5 cycles with core pending -> pipe_* stable, no grants; pipe_ready=1 -> grant same cycle.
REQ-025 Reset low while pipe_valid=1 -> pipe_valid=0 immediately, credits=CREDITS after release.
